// File: rtl/psum_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// psum_rmw_ctrl
//
// Read-modify-write sequencer between the ofifo, the single-port psum SRAM and
// the sfp stage. For every word of a command it reads the stored partial sum,
// presents it to sfp as acc_data, pops one ofifo row into sfp data_in and
// writes the registered sfp result back to the same SRAM address.
// With first_pass set the SRAM read is skipped and sfp overwrites (acc=0).
//
// Optional feature: define PSUM_RMW_STALL_CNT_EN to add o_stall_cnt, a
// saturating count of EX cycles spent waiting on an empty ofifo.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start                 command strobe, only sampled in IDLE
//   i_base_addr, i_len      first address and word count of the command
//   i_first_pass            1: skip SRAM read, sfp overwrites
//   o_busy, o_done          command in flight / one-cycle completion pulse
//   o_stall_cnt             (PSUM_RMW_STALL_CNT_EN only) ofifo stall cycles
//   i_ofifo_valid/_dout     ofifo head row, o_ofifo_rd pops it
//   o_mem_cen/_wen/_addr/_d SRAM control (active-low enables) and write data
//   i_mem_q                 SRAM read data, valid the cycle after a read
//   o_sfp_data_in/_acc_data/_acc  operands to sfp
//   i_sfp_data_out          registered sfp result
// -----------------------------------------------------------------------------
module psum_rmw_ctrl #(
    parameter int col    = 8,
    parameter int bw     = 16,
    parameter int addr_w = 11
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [addr_w-1:0]     i_base_addr,
    input  logic [addr_w-1:0]     i_len,
    input  logic                  i_first_pass,
    output logic                  o_busy,
    output logic                  o_done,
`ifdef PSUM_RMW_STALL_CNT_EN
    output logic [15:0]           o_stall_cnt,
`endif
    input  logic                  i_ofifo_valid,
    input  logic [col*bw-1:0]     i_ofifo_dout,
    output logic                  o_ofifo_rd,
    output logic                  o_mem_cen,
    output logic                  o_mem_wen,
    output logic [addr_w-1:0]     o_mem_addr,
    output logic [col*bw-1:0]     o_mem_d,
    input  logic [col*bw-1:0]     i_mem_q,
    output logic [col*bw-1:0]     o_sfp_data_in,
    output logic [col*bw-1:0]     o_sfp_acc_data,
    output logic                  o_sfp_acc,
    input  logic [col*bw-1:0]     i_sfp_data_out
);

    localparam int DW = col * bw;
    localparam logic [addr_w-1:0] ADDR_ZERO = {addr_w{1'b0}};
    localparam logic [addr_w-1:0] ADDR_ONE  = {{(addr_w-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LD   = 3'd2,
        S_EX   = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [addr_w-1:0] r_cur;
    logic [addr_w-1:0] w_cur_next;
    logic [addr_w-1:0] r_len;
    logic [addr_w-1:0] r_cnt;
    logic              r_fp;
    logic              w_fp_next;
    logic              w_accept;
    logic              w_last;

    logic              r_busy;
    logic              r_done;
    logic              r_mem_cen;
    logic              r_mem_wen;
    logic [addr_w-1:0] r_mem_addr;
    logic              r_sfp_acc;
    logic [DW-1:0]     r_acc_data;

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_last   = ((r_cnt + ADDR_ONE) == r_len);

    // Next-state, next address pointer and next first_pass flag.
    always_comb begin
        w_next     = r_state;
        w_cur_next = r_cur;
        w_fp_next  = r_fp;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_cur_next = i_base_addr;
                    w_fp_next  = i_first_pass;
                    // An empty command still spends one busy cycle (in LD,
                    // with the acc_data load suppressed) before done.
                    if (i_len == ADDR_ZERO) begin
                        w_next = S_LD;
                    end else if (i_first_pass) begin
                        w_next = S_EX;
                    end else begin
                        w_next = S_RD;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RD: begin
                w_next = S_LD;
            end
            S_LD: begin
                if (r_len == ADDR_ZERO) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_EX;
                end
            end
            S_EX: begin
                if (i_ofifo_valid) begin
                    w_next = S_WR;
                end else begin
                    w_next = S_EX;
                end
            end
            S_WR: begin
                // Address wraps silently modulo 2^addr_w.
                w_cur_next = r_cur + ADDR_ONE;
                if (w_last) begin
                    w_next = S_DONE;
                end else if (r_fp) begin
                    w_next = S_EX;
                end else begin
                    w_next = S_RD;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Command registers and words-written counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cur <= ADDR_ZERO;
            r_len <= ADDR_ZERO;
            r_cnt <= ADDR_ZERO;
            r_fp  <= 1'b0;
        end else begin
            r_cur <= w_cur_next;
            r_fp  <= w_fp_next;
            if (w_accept) begin
                r_len <= i_len;
                r_cnt <= ADDR_ZERO;
            end else if (r_state == S_WR) begin
                r_cnt <= r_cnt + ADDR_ONE;
            end
        end
    end

    // Registered control outputs, decoded from the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_cen  <= 1'b1;
            r_mem_wen  <= 1'b1;
            r_mem_addr <= ADDR_ZERO;
            r_sfp_acc  <= 1'b0;
        end else begin
            r_busy    <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done    <= (w_next == S_DONE);
            r_mem_cen <= !((w_next == S_RD) || (w_next == S_WR));
            r_mem_wen <= !(w_next == S_WR);
            r_sfp_acc <= (w_next == S_EX) && !w_fp_next;
            if ((w_next == S_RD) || (w_next == S_WR)) begin
                r_mem_addr <= w_cur_next;
            end
        end
    end

    // acc_data holder: sfp re-samples it every cycle, so it only changes in LD
    // (or is zeroed when a first_pass command is accepted).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc_data <= {DW{1'b0}};
        end else if (w_accept && i_first_pass) begin
            r_acc_data <= {DW{1'b0}};
        end else if ((r_state == S_LD) && (r_len != ADDR_ZERO)) begin
            r_acc_data <= i_mem_q;
        end
    end

`ifdef PSUM_RMW_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of EX cycles waiting on an empty ofifo.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_accept) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == S_EX) && !i_ofifo_valid && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    // The SRAM enables are forced inactive while reset is high so an aborted
    // WR never reaches the array at the reset edge.
    assign o_mem_cen      = r_mem_cen | i_reset;
    assign o_mem_wen      = r_mem_wen | i_reset;
    assign o_mem_addr     = r_mem_addr;
    // Write data is the sfp result registered at the end of EX, so it can only
    // be passed through during WR.
    assign o_mem_d        = (r_state == S_WR) ? i_sfp_data_out : {DW{1'b0}};
    assign o_ofifo_rd     = (r_state == S_EX) && i_ofifo_valid && !i_reset;
    assign o_sfp_data_in  = (r_state == S_EX) ? i_ofifo_dout : {DW{1'b0}};
    assign o_sfp_acc_data = r_acc_data;
    assign o_sfp_acc      = r_sfp_acc;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_psum_rmw_ctrl.sv
// Scoreboard bench for psum_rmw_ctrl with SRAM, ofifo and sfp environment models.
module tb_psum_rmw_ctrl;
    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int AW    = 11;
    localparam int DW    = COL * BW;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len;
    logic          first_pass;
    logic          busy;
    logic          done;
    logic          ofifo_valid;
    logic [DW-1:0] ofifo_dout;
    logic          ofifo_rd;
    logic          mem_cen;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] sfp_data_in;
    logic [DW-1:0] sfp_acc_data;
    logic          sfp_acc;
    logic [DW-1:0] sfp_data_out;
`ifdef PSUM_RMW_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    psum_rmw_ctrl #(.col(COL), .bw(BW), .addr_w(AW)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base_addr),
        .i_len(len), .i_first_pass(first_pass), .o_busy(busy), .o_done(done),
`ifdef PSUM_RMW_STALL_CNT_EN
        .o_stall_cnt(stall_cnt),
`endif
        .i_ofifo_valid(ofifo_valid), .i_ofifo_dout(ofifo_dout), .o_ofifo_rd(ofifo_rd),
        .o_mem_cen(mem_cen), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr), .o_mem_d(mem_d),
        .i_mem_q(mem_q), .o_sfp_data_in(sfp_data_in), .o_sfp_acc_data(sfp_acc_data),
        .o_sfp_acc(sfp_acc), .i_sfp_data_out(sfp_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] acc;
        logic [DW-1:0] row;
        logic [DW-1:0] data;
        logic          fp;
        int            wcyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ofifo_q[$];
    logic [DW-1:0] sram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_done_cyc = -1;
    int   n_rd = 0, n_wr = 0, n_pop = 0, n_done = 0;
    logic cur_fp = 1'b0;
    int   stall_mode = 0;
    int   stall_left = 0;
    exp_t mon_e;

    function automatic logic [DW-1:0] vadd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        for (int e = 0; e < COL; e++) r[e*BW +: BW] = a[e*BW +: BW] + b[e*BW +: BW];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int e = 0; e < COL; e++) v[e*BW +: BW] = 16'($urandom);
        return v;
    endfunction

    function automatic logic [DW-1:0] splat(input logic [BW-1:0] x);
        logic [DW-1:0] v;
        for (int e = 0; e < COL; e++) v[e*BW +: BW] = x;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read data, write on active-low cen/wen.
    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) sram[mem_addr] <= mem_d;
            else          mem_q <= sram[mem_addr];
        end
    end

    // sfp model: registered result, overwrite when acc=0.
    always @(posedge clk) sfp_data_out <= sfp_acc ? vadd(sfp_acc_data, sfp_data_in) : sfp_data_in;

    // ofifo model: pop on rd, then present the head with optional stalls.
    always @(posedge clk) begin
        logic stall;
        if (ofifo_rd && ofifo_q.size() > 0) void'(ofifo_q.pop_front());
        #1;
        stall = 1'b0;
        if (stall_mode == 1) begin
            stall = ($urandom_range(0, 3) == 0);
        end else if (stall_mode == 2 && stall_left > 0 && sfp_acc) begin
            stall = 1'b1;
            stall_left--;
        end
        ofifo_valid = (ofifo_q.size() > 0) && !stall;
        ofifo_dout  = (ofifo_q.size() > 0) ? ofifo_q[0] : '0;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            check("no_sram_in_reset", mem_cen, 1);
        end else begin
            if (!mem_cen && !mem_wen) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", mem_addr, mon_e.addr);
                    check("wr_data", mem_d, mon_e.data);
                    check("busy_on_wr", busy, 1);
                    if (mon_e.wcyc >= 0) check("wr_cycle", cyc, mon_e.wcyc);
                    ref_mem[mon_e.addr] = mon_e.data;
                end
            end
            if (!mem_cen && mem_wen) begin
                n_rd++;
                if (cur_fp) check("read_in_first_pass", 1, 0);
                else if (exp_q.size() > 0) check("rd_addr", mem_addr, exp_q[0].addr);
            end
            if (ofifo_rd) begin
                n_pop++;
                check("rd_only_when_valid", ofifo_valid, 1);
                if (exp_q.size() > 0) begin
                    check("sfp_data_in", sfp_data_in, exp_q[0].row);
                    check("sfp_acc_flag", sfp_acc, !exp_q[0].fp);
                    check("sfp_acc_data", sfp_acc_data, exp_q[0].acc);
                end
            end
            if (sfp_acc && exp_q.size() > 0) check("acc_data_hold", sfp_acc_data, exp_q[0].acc);
            if (done) begin
                n_done++;
                check("queue_empty_at_done", exp_q.size(), 0);
                check("busy_low_at_done", busy, 0);
                if (exp_done_cyc >= 0) check("done_cycle", cyc, exp_done_cyc);
            end
        end
    end

    // Queue expectations and rows for a command; returns the start cycle.
    task automatic issue(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic fp,
                         input int smode, input bit timed, input bit fixed, input logic [DW-1:0] frow);
        int off;
        int sc;
        exp_t e;
        @(posedge clk); #1;
        stall_mode = smode;
        stall_left = (smode == 2) ? 6 : 0;
        off = (smode == 2) ? 6 : 0;
        sc = cyc;
        for (int k = 0; k < int'(l); k++) begin
            e.addr = AW'(b + AW'(k));
            e.fp   = fp;
            e.row  = fixed ? frow : rand_vec();
            e.acc  = fp ? '0 : ref_mem[e.addr];
            e.data = fp ? e.row : vadd(e.acc, e.row);
            e.wcyc = timed ? (fp ? sc + 2 + 2*k : sc + 4 + 4*k + off) : -1;
            exp_q.push_back(e);
            ofifo_q.push_back(e.row);
        end
        cur_fp = fp;
        exp_done_cyc = !timed ? -1 : (l == 0) ? sc + 2 : fp ? sc + 2*int'(l) + 1 : sc + 4*int'(l) + 1 + off;
        start = 1'b1; base_addr = b; len = l; first_pass = fp;
    endtask

    task automatic run_cmd(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic fp,
                           input int smode, input bit timed, input bit restart,
                           input bit fixed, input logic [DW-1:0] frow);
        int c0;
        issue(b, l, fp, smode, timed, fixed, frow);
        @(posedge clk); #1;
        start = 1'b0;
        if (restart) begin
            start = 1'b1; base_addr = b + 11'd100; len = 11'd1; first_pass = !fp;
        end
        @(negedge clk);
        check("busy_after_start", busy, 1);
        if (restart) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        c0 = 0;
        while (!done && c0 < 600) begin
            @(negedge clk);
            c0++;
        end
        if (!done) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_idle", busy, 0);
        stall_mode = 0;
    endtask

    initial begin
        int r0, w0, p0, d0, c0;
        logic [DW-1:0] old_word;
        reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; first_pass = 1'b0;
        ofifo_valid = 1'b0; ofifo_dout = '0; mem_q = '0; sfp_data_out = '0;
        for (int a = 0; a < DEPTH; a++) begin
            sram[a] = rand_vec();
            ref_mem[a] = sram[a];
        end
        for (int a = 0; a < 3; a++) begin
            sram[(2046 + a) % DEPTH] = splat(16'd5);
            ref_mem[(2046 + a) % DEPTH] = splat(16'd5);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cen", mem_cen, 1);
        check("rst_wen", mem_wen, 1);
        check("rst_ofifo_rd", ofifo_rd, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_mem_d", mem_d, 0);
        check("rst_data_in", sfp_data_in, 0);
        check("rst_acc_data", sfp_acc_data, 0);
        check("rst_acc", sfp_acc, 0);

        // first_pass, len 3
        r0 = n_rd; p0 = n_pop; w0 = n_wr;
        run_cmd(11'h010, 11'd3, 1'b1, 0, 1'b1, 1'b0, 1'b0, '0);
        check("fp_reads", n_rd - r0, 0);
        check("fp_pops", n_pop - p0, 3);
        check("fp_writes", n_wr - w0, 3);

        // accumulate with address wrap, 5 + 3 = 8
        run_cmd(11'h7FE, 11'd3, 1'b0, 0, 1'b1, 1'b0, 1'b1, splat(16'd3));
        check("wrap_word", sram[0], splat(16'd8));

        // six-cycle stall in the first EX
        run_cmd(11'h050, 11'd2, 1'b0, 2, 1'b1, 1'b0, 1'b0, '0);
`ifdef PSUM_RMW_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 6);
`endif

        // start while busy is ignored, then an empty command
        run_cmd(11'h300, 11'd3, 1'b1, 0, 1'b1, 1'b1, 1'b0, '0);
        r0 = n_rd; w0 = n_wr; p0 = n_pop; d0 = n_done;
        run_cmd(11'h123, 11'd0, 1'b0, 0, 1'b1, 1'b0, 1'b0, '0);
        check("len0_reads", n_rd - r0, 0);
        check("len0_writes", n_wr - w0, 0);
        check("len0_pops", n_pop - p0, 0);
        check("len0_done", n_done - d0, 1);

        // reset in the WR of word 2 of a len 4 command
        old_word = sram[11'h101];
        w0 = n_wr;
        issue(11'h100, 11'd4, 1'b1, 0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        start = 1'b0;
        c0 = 0;
        while (!(!mem_wen && mem_addr == 11'h101) && c0 < 40) begin
            @(posedge clk); #1;
            c0++;
        end
        check("abort_reached_wr2", !mem_wen && mem_addr == 11'h101, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_cen", mem_cen, 1);
        check("abort_wen", mem_wen, 1);
        check("abort_addr", mem_addr, 0);
        check("abort_ofifo_rd", ofifo_rd, 0);
        check("abort_acc", sfp_acc, 0);
        check("abort_acc_data", sfp_acc_data, 0);
        check("abort_mem_d", mem_d, 0);
        check("abort_data_in", sfp_data_in, 0);
        check("abort_writes", n_wr - w0, 1);
        check("abort_pending", exp_q.size(), 3);
        check("abort_word_kept", sram[11'h101], old_word);
        exp_q.delete();
        ofifo_q.delete();
        run_cmd(11'h200, 11'd3, 1'b0, 0, 1'b1, 1'b0, 1'b0, '0);

        // randomized commands with random ofifo stalls
        repeat (25) begin
            run_cmd(AW'($urandom), AW'($urandom_range(1, 6)), 1'($urandom), 1, 1'b0, 1'b0, 1'b0, '0);
        end

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/psum_rmw_ctrl.md
Name: psum_rmw_ctrl

Overview:
- Read-modify-write sequencer that feeds the sfp stage and writes its results back.
- Per word:
  - reads the stored partial sum from single-port psum SRAM and presents it to sfp as acc_data;
  - pops one ofifo row into sfp data_in;
  - writes sfp data_out back to the same SRAM address.
- Sits between ofifo, psum SRAM and sfp. It is the source of sfp's acc_data/data_in/acc and the sink of sfp's data_out.

Parameters:
col, 8, columns per psum word
bw, 16, bits per psum element
addr_w, 11, psum SRAM address width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  command strobe, sampled only in IDLE
base_addr  input  addr_w  first psum address of command
len  input  addr_w  number of words to process
first_pass  input  1  1: no SRAM read; sfp acc=0 (overwrite)
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after last write
ofifo_valid  input  1  ofifo has a row
ofifo_dout  input  col*bw  ofifo head row
ofifo_rd  output  1  pop ofifo head
mem_cen  output  1  SRAM chip enable, active low
mem_wen  output  1  SRAM write enable, active low
mem_addr  output  addr_w  SRAM address
mem_d  output  col*bw  SRAM write data
mem_q  input  col*bw  SRAM read data, valid the cycle after a read
sfp_data_in  output  col*bw  to sfp data_in
sfp_acc_data  output  col*bw  to sfp acc_data
sfp_acc  output  1  to sfp acc
sfp_data_out  input  col*bw  from sfp data_out (registered in sfp)

Behaviour:
- Reset values:
  - busy=0, done=0, ofifo_rd=0, mem_cen=1, mem_wen=1, mem_addr=0, mem_d=0;
  - sfp_data_in=0, sfp_acc_data=0, sfp_acc=0;
  - state=IDLE, word counter=0.
- Reset mid-command aborts immediately. No SRAM write occurs in the reset cycle.
- Command capture: IDLE with start=1 latches base_addr, len and first_pass; busy rises next cycle.
  - start while busy is ignored.
  - len=0: busy for 1 cycle, then done pulse, no SRAM or ofifo activity.
- FSM states: IDLE, RD, LD, EX, WR, DONE.
  - RD: mem_cen=0, mem_wen=1, mem_addr=cur. If first_pass, skip RD/LD and go to EX with sfp_acc_data held at 0.
  - LD: sfp_acc_data register loads mem_q and is held stable until the next LD, because sfp re-samples acc_data every cycle. mem_cen=1. Next state EX.
  - EX: sfp_data_in=ofifo_dout, sfp_acc=~first_pass.
    - ofifo_valid=0: stay in EX (stall), ofifo_rd=0, no side effects.
    - ofifo_valid=1: ofifo_rd=1 for exactly that cycle, then go to WR.
  - WR: mem_cen=0, mem_wen=0, mem_addr=cur, mem_d=sfp_data_out (result of the EX cycle).
    - cur increments modulo 2^addr_w (base_addr+len may wrap to 0).
    - If words written == len, go to DONE; else go to RD (or EX if first_pass).
  - DONE: done=1 for one cycle, busy=0 after it, then IDLE.
- sfp_data_in is 0 outside EX. sfp_acc is 0 outside EX.
- Throughput: 4 cycles/word (accumulate) or 2 cycles/word (first_pass), plus stall cycles.
  - Latency from start to first mem write: 4 cycles (accumulate), 2 cycles (first_pass).
- Never both reads and writes the SRAM in one cycle. mem_cen=1 in IDLE, LD, EX and DONE.
- No arithmetic in this block. Widths pass through unchanged; the address counter wraps silently.

Optional Feature:
- Macro: PSUM_RMW_STALL_CNT_EN.
- Defined:
  - adds output stall_cnt (16 bits);
  - cleared on reset and on accepted start;
  - increments each EX cycle with ofifo_valid=0;
  - saturates at 16'hFFFF;
  - holds its value after done.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, mem_cen=1, ofifo_rd=0, all data outputs 0.
- first_pass=1, base_addr=0x010, len=3, ofifo always valid, sfp model returns data_in -> writes at 0x010/0x011/0x012 on cycles 2/4/6 after start. done on cycle 7. Exactly 3 ofifo_rd pulses. No reads.
- Accumulate: base_addr=0x7FE, len=3, SRAM preloaded with 5 per element, ofifo rows of 3 per element -> reads/writes at 0x7FE, 0x7FF, 0x000 (wrap). sfp_acc_data=5 held through EX. Written value 8 per element.
- ofifo_valid low 6 cycles during first EX -> FSM holds EX, ofifo_rd=0, no SRAM access, sfp_acc_data stable. Result identical to the no-stall run. With PSUM_RMW_STALL_CNT_EN: stall_cnt=6.
- start pulsed again while busy, plus len=0 command -> second start ignored. len=0 gives done one cycle after busy with zero SRAM/ofifo activity.
- reset asserted in WR of word 2 of len=4 -> that write suppressed, outputs at reset values next cycle. New start afterwards runs cleanly from its base_addr.
